// File: rtl/bench_pkg.sv
// Shared types and constants for the benchmark run controller.
//   bench_state_t : run sequencer states (encoding is exported on the debug LEDs)
//   CYCLE_W       : width of the cycle counters and records
//   sat_inc8      : saturating 8-bit increment used for the completed-run counter
package bench_pkg;

  localparam int CYCLE_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } bench_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bench_run_ctrl_rise_detect.sv
// Rising-edge detector for a level input (buttons, keys).
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   level_i : level input, assumed already synchronous to clk
//   pulse_o : high for the single cycle in which level_i is high and was low
//             on the previous cycle
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/bench_run_ctrl.sv
// Benchmark run sequencer for the CPU.
// Holds the CPU in reset until a start request, releases it after a fixed
// hold, counts cycles until the PC reaches FINAL_PC or a timeout, and keeps
// the last/best cycle records for the performance displays.
//   CLK_50       : system clock
//   resetN       : asynchronous active-low reset
//   start        : start/restart request (level, rising edge used)
//   clear_best   : clears the best record while not holding/running
//   pc           : CPU program counter, looked at only in RUN
//   cpu_resetN   : active-low reset to the CPU core
//   running      : high while in RUN
//   cycle_count  : live RUN cycle count
//   last_cycles  : cycles of the last completed run
//   best_cycles  : minimum completed-run cycles (valid when best_valid)
//   best_valid   : best_cycles holds a real result
//   run_count    : completed runs, saturating at 255
//   timed_out    : last run ended by timeout
//   state        : current state encoding
module bench_run_ctrl
  import bench_pkg::*;
#(
  parameter logic [15:0]        FINAL_PC          = 16'h0000,
  parameter int unsigned        RESET_HOLD_CYCLES = 16,
  parameter logic [CYCLE_W-1:0] TIMEOUT_CYCLES    = 32'd500_000_000
) (
  input  logic               CLK_50,
  input  logic               resetN,
  input  logic               start,
  input  logic               clear_best,
  input  logic [15:0]        pc,
  output logic               cpu_resetN,
  output logic               running,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] last_cycles,
  output logic [CYCLE_W-1:0] best_cycles,
  output logic               best_valid,
  output logic [7:0]         run_count,
  output logic               timed_out,
  output logic [2:0]         state
);

  // hold_cnt counts down to zero; the cycle it reads zero is the last HOLD cycle.
  localparam logic [15:0] HOLD_LOAD = 16'(RESET_HOLD_CYCLES - 1);

  bench_state_t       state_q;
  logic [15:0]        hold_cnt_q;
  logic [CYCLE_W-1:0] cycle_count_q;
  logic [CYCLE_W-1:0] last_cycles_q;
  logic [CYCLE_W-1:0] best_cycles_q;
  logic               best_valid_q;
  logic [7:0]         run_count_q;
  logic               timed_out_q;

  logic               start_pulse;
  logic [CYCLE_W:0]   cycle_plus1;
  logic               records_idle;

  rise_detect u_start_rise (
    .clk     (CLK_50),
    .rst_n   (resetN),
    .level_i (start),
    .pulse_o (start_pulse)
  );

  // One extra bit so the timeout/best comparisons never wrap.
  assign cycle_plus1  = {1'b0, cycle_count_q} + {{CYCLE_W{1'b0}}, 1'b1};
  assign records_idle = (state_q == IDLE) || (state_q == DONE) || (state_q == TIMEOUT);

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      last_cycles_q <= '0;
      best_cycles_q <= '0;
      best_valid_q  <= 1'b0;
      run_count_q   <= '0;
      timed_out_q   <= 1'b0;
    end else begin
      // Only possible outside HOLD/RUN, so it never collides with a finish
      // recording the best value in the same cycle.
      if (clear_best && records_idle) begin
        best_valid_q  <= 1'b0;
        best_cycles_q <= '0;
      end

      // A start pulse (re)starts from any state except HOLD; in RUN it aborts
      // the run and overrides that cycle's finish/timeout.
      if (start_pulse && (state_q != HOLD)) begin
        state_q     <= HOLD;
        hold_cnt_q  <= HOLD_LOAD;
        timed_out_q <= 1'b0;
      end else begin
        unique case (state_q)
          HOLD: begin
            if (hold_cnt_q == 16'd0) begin
              state_q       <= RUN;
              cycle_count_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q - 16'd1;
            end
          end
          RUN: begin
            if (pc == FINAL_PC) begin
              // Finish wins over a simultaneous timeout.
              last_cycles_q <= cycle_plus1[CYCLE_W-1:0];
              run_count_q   <= sat_inc8(run_count_q);
              state_q       <= DONE;
              if (!best_valid_q || (cycle_plus1 < {1'b0, best_cycles_q})) begin
                best_cycles_q <= cycle_plus1[CYCLE_W-1:0];
                best_valid_q  <= 1'b1;
              end
            end else if (cycle_plus1 == {1'b0, TIMEOUT_CYCLES}) begin
              state_q     <= TIMEOUT;
              timed_out_q <= 1'b1;
            end else begin
              cycle_count_q <= cycle_plus1[CYCLE_W-1:0];
            end
          end
          IDLE, DONE, TIMEOUT: begin
            // Wait for a start pulse; counters stay frozen.
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The CPU stays out of reset in DONE so its final screen remains visible.
  assign cpu_resetN  = (state_q == RUN) || (state_q == DONE);
  assign running     = (state_q == RUN);
  assign state       = state_q;
  assign cycle_count = cycle_count_q;
  assign last_cycles = last_cycles_q;
  assign best_cycles = best_cycles_q;
  assign best_valid  = best_valid_q;
  assign run_count   = run_count_q;
  assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_bench_run_ctrl.sv
module tb_bench_run_ctrl;

  localparam logic [15:0] FPC  = 16'h0042;
  localparam int          HOLD = 4;
  localparam int          TMO  = 100;

  // Reference model phase labels (numeric values match the debug encoding).
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_DONE = 3, M_TMO = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        clear_best = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        cpu_resetN, running, best_valid, timed_out;
  logic [31:0] cycle_count, last_cycles, best_cycles;
  logic [7:0]  run_count;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: how far we are in the run, plus the records.
  int          m_mode;
  int          m_hold_left;   // HOLD cycles still to spend, including the current one
  int unsigned m_cyc, m_last, m_best, m_runs;
  bit          m_bvalid, m_to, m_prev_start;

  bench_run_ctrl #(
    .FINAL_PC          (FPC),
    .RESET_HOLD_CYCLES (HOLD),
    .TIMEOUT_CYCLES    (32'd100)
  ) dut (
    .CLK_50      (clk),
    .resetN      (resetN),
    .start       (start),
    .clear_best  (clear_best),
    .pc          (pc),
    .cpu_resetN  (cpu_resetN),
    .running     (running),
    .cycle_count (cycle_count),
    .last_cycles (last_cycles),
    .best_cycles (best_cycles),
    .best_valid  (best_valid),
    .run_count   (run_count),
    .timed_out   (timed_out),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_hold_left = 0; m_cyc = 0; m_last = 0; m_best = 0;
    m_runs = 0; m_bvalid = 0; m_to = 0; m_prev_start = 0;
  endtask

  task automatic model_step(input bit s, input logic [15:0] p, input bit c);
    bit pulse;
    int unsigned n;
    pulse = s && !m_prev_start;
    m_prev_start = s;
    if (c && (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_TMO)) begin
      m_best = 0; m_bvalid = 0;
    end
    if (pulse && m_mode != M_HOLD) begin
      m_mode = M_HOLD; m_hold_left = HOLD; m_to = 0;
    end else if (m_mode == M_HOLD) begin
      if (m_hold_left == 1) begin m_mode = M_RUN; m_cyc = 0; end
      else m_hold_left--;
    end else if (m_mode == M_RUN) begin
      n = m_cyc + 1;
      if (p == FPC) begin
        m_last = n;
        if (!m_bvalid || n < m_best) begin m_best = n; m_bvalid = 1; end
        if (m_runs < 255) m_runs++;
        m_mode = M_DONE;
      end else if (n == TMO) begin
        m_mode = M_TMO; m_to = 1;
      end else begin
        m_cyc = n;
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check_eq({pfx, ".state"},       32'(state),       32'(m_mode));
    check_eq({pfx, ".cpu_resetN"},  32'(cpu_resetN),  32'(m_mode == M_RUN || m_mode == M_DONE));
    check_eq({pfx, ".running"},     32'(running),     32'(m_mode == M_RUN));
    check_eq({pfx, ".cycle_count"}, cycle_count,      m_cyc);
    check_eq({pfx, ".last_cycles"}, last_cycles,      m_last);
    check_eq({pfx, ".best_cycles"}, best_cycles,      m_best);
    check_eq({pfx, ".best_valid"},  32'(best_valid),  32'(m_bvalid));
    check_eq({pfx, ".run_count"},   32'(run_count),   m_runs);
    check_eq({pfx, ".timed_out"},   32'(timed_out),   32'(m_to));
  endtask

  // One clock cycle: check at the falling edge, drive, optionally pulse the
  // asynchronous reset, then advance the model on the rising edge.
  task automatic cycle(input bit s, input logic [15:0] p, input bit c, input bit r);
    @(negedge clk);
    check_outputs("cyc");
    start = s; pc = p; clear_best = c;
    if (r) begin
      resetN = 1'b0;
      #1;
      model_reset();
      check_outputs("arst");
    end else begin
      resetN = 1'b1;
    end
    @(posedge clk);
    if (!resetN) model_reset();
    else model_step(s, p, c);
  endtask

  // Start pulse, full hold, then n RUN cycles; pc matches on the last one if asked.
  task automatic run_once(input int n, input bit match);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (HOLD) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (n - 1) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, match ? FPC : 16'h0001, 1'b0, 1'b0);
  endtask

  initial begin
    bit          rs;
    logic [15:0] rp;
    model_reset();
    #1;
    check_outputs("por");
    repeat (2) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Plan 1: finish on the 10th RUN cycle.
    run_once(10, 1'b1);
    #1;
    check_eq("tp1.last", last_cycles, 32'd10);
    check_eq("tp1.best", best_cycles, 32'd10);
    check_eq("tp1.state", 32'(state), 32'd3);
    check_eq("tp1.cpu_resetN", 32'(cpu_resetN), 32'd1);

    // Plan 2: new best, then a slower run.
    run_once(7, 1'b1);
    #1;
    check_eq("tp2.best7", best_cycles, 32'd7);
    run_once(12, 1'b1);
    #1;
    check_eq("tp2.last", last_cycles, 32'd12);
    check_eq("tp2.best", best_cycles, 32'd7);
    check_eq("tp2.runs", 32'(run_count), 32'd3);

    // Plan 3: timeout after exactly TMO RUN cycles.
    run_once(TMO, 1'b0);
    #1;
    check_eq("tp3.state", 32'(state), 32'd4);
    check_eq("tp3.timed_out", 32'(timed_out), 32'd1);
    check_eq("tp3.cpu_resetN", 32'(cpu_resetN), 32'd0);
    check_eq("tp3.last", last_cycles, 32'd12);
    check_eq("tp3.runs", 32'(run_count), 32'd3);

    // Plan 4: finish coinciding with timeout.
    run_once(TMO, 1'b1);
    #1;
    check_eq("tp4.state", 32'(state), 32'd3);
    check_eq("tp4.last", last_cycles, 32'd100);
    check_eq("tp4.timed_out", 32'(timed_out), 32'd0);

    // Plan 5: abort at RUN cycle 5 (with a pc match that must be ignored),
    // then keep start high: only one restart.
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (HOLD + 4) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, FPC, 1'b0, 1'b0);
    #1;
    check_eq("tp5.state", 32'(state), 32'd1);
    check_eq("tp5.runs", 32'(run_count), 32'd4);
    repeat (49) cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    #1;
    check_eq("tp5.still_run", 32'(state), 32'd2);
    cycle(1'b0, FPC, 1'b0, 1'b0);

    // Plan 6: reset mid-RUN, clear_best in DONE, run_count saturation.
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (HOLD + 3) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    run_once(3, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    #1;
    check_eq("tp6.best_valid", 32'(best_valid), 32'd0);
    check_eq("tp6.best", best_cycles, 32'd0);
    repeat (260) run_once(1 + $urandom_range(0, 2), 1'b1);
    #1;
    check_eq("tp6.sat", 32'(run_count), 32'd255);

    // Randomised traffic against the model.
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      if ($urandom_range(0, 11) == 0) rp = FPC;
      else rp = 16'($urandom);
      cycle(rs, rp, $urandom_range(0, 39) == 0, $urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    check_outputs("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
